// File: rtl/segre_pkg.sv
// Shared types and sizing for the segre memory-side arbiter.
// The I-cache and D-cache line ports share one memory channel.
package segre_pkg;

    localparam int ADDR_SIZE            = 32;
    localparam int CACHE_LINE_SIZE_BITS = 128;

    typedef enum logic [1:0] {
        IDLE,
        IC_BUSY,
        DC_BUSY,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWNER_IC,
        OWNER_DC
    } arb_owner_e;

    // Number of byte-offset bits inside one cache line.
    function automatic int line_offset_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/segre_arb_prio.sv
// I/D priority decision for the memory arbiter.
// The D-side wins contention until it has taken MAX_DC_STREAK grants in a row.
module segre_arb_prio
    import segre_pkg::*;
#(
    parameter int MAX_DC_STREAK = 4,
    parameter int STREAK_W      = $clog2(MAX_DC_STREAK + 1)
) (
    input  logic clk_i,
    input  logic rsn_i,
    input  logic arb_en,
    input  logic ic_req,
    input  logic dc_req,
    output logic grant_ic,
    output logic grant_dc
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DC_STREAK);

    logic [STREAK_W-1:0] streak_q;

    // NOTE: every output gets a value before any condition, so no latch can be inferred.
    always_comb begin
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (arb_en) begin
            grant_dc = dc_req && (!ic_req || (streak_q != STREAK_MAX));
            grant_ic = ic_req && !grant_dc;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same edge values.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            streak_q <= '0;
        end else if (grant_ic) begin
            streak_q <= '0;
        end else if (grant_dc) begin
            if (!ic_req) begin
                streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Two-requester memory arbiter: one outstanding line transaction at a time,
// with a registered memory interface and a one-cycle completion pulse per owner.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int ADDR_W        = ADDR_SIZE,
    parameter int LINE_W        = CACHE_LINE_SIZE_BITS,
    parameter int MAX_DC_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_rvalid_o,
    output logic [LINE_W-1:0] ic_rdata_o,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              dc_rvalid_o,
    output logic [LINE_W-1:0] dc_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    localparam logic [ADDR_W-1:0] ADDR_MASK =
        ~ADDR_W'((1 << line_offset_bits(LINE_W)) - 1);

    arb_state_e state;
    arb_owner_e owner;
    logic       grant_ic;
    logic       grant_dc;

    segre_arb_prio #(
        .MAX_DC_STREAK(MAX_DC_STREAK)
    ) u_prio (
        .clk_i   (clk_i),
        .rsn_i   (rsn_i),
        .arb_en  (state == IDLE),
        .ic_req  (ic_req_i),
        .dc_req  (dc_req_i),
        .grant_ic(grant_ic),
        .grant_dc(grant_dc)
    );

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state       <= IDLE;
            owner       <= OWNER_IC;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ic_rvalid_o <= 1'b0;
            dc_rvalid_o <= 1'b0;
            ic_rdata_o  <= '0;
            dc_rdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dc) begin
                        state       <= DC_BUSY;
                        owner       <= OWNER_DC;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dc_we_i;
                        mem_addr_o  <= dc_addr_i & ADDR_MASK;
                        mem_wdata_o <= dc_wdata_i;
                    end else if (grant_ic) begin
                        state       <= IC_BUSY;
                        owner       <= OWNER_IC;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= ic_addr_i & ADDR_MASK;
                        mem_wdata_o <= '0;
                    end
                end
                IC_BUSY, DC_BUSY: begin
                    // Requesters may drop req here; the transaction still runs to completion.
                    if (mem_ack_i) begin
                        state     <= RESP;
                        mem_req_o <= 1'b0;
                        if (owner == OWNER_IC) begin
                            ic_rdata_o  <= mem_rdata_i;
                            ic_rvalid_o <= 1'b1;
                        end else begin
                            dc_rdata_o  <= mem_rdata_i;
                            dc_rvalid_o <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    ic_rvalid_o <= 1'b0;
                    dc_rvalid_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: hand-computed vectors checked with
// immediate assertions, inputs driven and outputs sampled 1 ns after each rising edge.
module tb_segre_mem_arbiter;
    import segre_pkg::*;

    logic         clk_i = 1'b0;
    logic         rsn_i;
    logic         ic_req_i;
    logic [31:0]  ic_addr_i;
    logic         ic_rvalid_o;
    logic [127:0] ic_rdata_o;
    logic         dc_req_i;
    logic         dc_we_i;
    logic [31:0]  dc_addr_i;
    logic [127:0] dc_wdata_i;
    logic         dc_rvalid_o;
    logic [127:0] dc_rdata_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [127:0] mem_rdata_i;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] DATA_A5 = {16{8'hA5}};
    localparam logic [127:0] DATA_11 = {16{8'h11}};
    localparam logic [127:0] DATA_5C = {16{8'h5C}};
    localparam logic [127:0] DATA_E7 = {16{8'hE7}};

    segre_mem_arbiter dut (
        .clk_i      (clk_i),
        .rsn_i      (rsn_i),
        .ic_req_i   (ic_req_i),
        .ic_addr_i  (ic_addr_i),
        .ic_rvalid_o(ic_rvalid_o),
        .ic_rdata_o (ic_rdata_o),
        .dc_req_i   (dc_req_i),
        .dc_we_i    (dc_we_i),
        .dc_addr_i  (dc_addr_i),
        .dc_wdata_i (dc_wdata_i),
        .dc_rvalid_o(dc_rvalid_o),
        .dc_rdata_o (dc_rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance until mem_req_o rises; an expired budget counts as a failure.
    task automatic wait_mem_req(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (mem_req_o === 1'b1) break;
        end
        if (i == budget) check({tag, "_timeout"}, 128'(mem_req_o), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         exp_dc [6];
        logic [2:0]   exp_streak [6];

        rsn_i = 1'b0; ic_req_i = 1'b0; ic_addr_i = '0;
        dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        tick(); tick();

        // Reset state
        check("rst_state",     128'(dut.state), 128'(IDLE));
        check("rst_mem_req",   128'(mem_req_o), 128'd0);
        check("rst_mem_we",    128'(mem_we_o), 128'd0);
        check("rst_mem_addr",  128'(mem_addr_o), 128'd0);
        check("rst_ic_rvalid", 128'(ic_rvalid_o), 128'd0);
        check("rst_dc_rvalid", 128'(dc_rvalid_o), 128'd0);
        check("rst_streak",    128'(dut.u_prio.streak_q), 128'd0);
        rsn_i = 1'b1;
        tick();

        // I-side fill, unaligned address, ack two cycles after mem_req_o
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_1234;
        tick();
        check("ic_mem_req",  128'(mem_req_o), 128'd1);
        check("ic_mem_addr", 128'(mem_addr_o), 128'h0000_1230);
        check("ic_mem_we",   128'(mem_we_o), 128'd0);
        check("ic_state",    128'(dut.state), 128'(IC_BUSY));
        tick();
        check("ic_req_held",  128'(mem_req_o), 128'd1);
        check("ic_addr_held", 128'(mem_addr_o), 128'h0000_1230);
        mem_ack_i = 1'b1; mem_rdata_i = DATA_A5;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        check("ic_rvalid",      128'(ic_rvalid_o), 128'd1);
        check("ic_rdata",       ic_rdata_o, DATA_A5);
        check("ic_no_dc_valid", 128'(dc_rvalid_o), 128'd0);
        check("ic_req_dropped", 128'(mem_req_o), 128'd0);
        ic_req_i = 1'b0;
        tick();
        check("ic_rvalid_1cyc", 128'(ic_rvalid_o), 128'd0);
        check("ic_rdata_hold",  ic_rdata_o, DATA_A5);
        check("ic_back_idle",   128'(dut.state), 128'(IDLE));

        // D-side write-back
        dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h0000_2000; dc_wdata_i = DATA_11;
        tick();
        check("wb_mem_req",   128'(mem_req_o), 128'd1);
        check("wb_mem_we",    128'(mem_we_o), 128'd1);
        check("wb_mem_addr",  128'(mem_addr_o), 128'h0000_2000);
        check("wb_mem_wdata", mem_wdata_o, DATA_11);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("wb_dc_rvalid", 128'(dc_rvalid_o), 128'd1);
        check("wb_no_ic",     128'(ic_rvalid_o), 128'd0);
        dc_req_i = 1'b0; dc_we_i = 1'b0;
        tick();
        check("wb_rvalid_1cyc", 128'(dc_rvalid_o), 128'd0);
        check("wb_streak",      128'(dut.u_prio.streak_q), 128'd0);

        // Both requesters held: dc,dc,dc,dc,ic,dc
        exp_dc     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_streak = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_0100;
        dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h0000_0200;
        for (int k = 0; k < 6; k++) begin
            wait_mem_req($sformatf("fair%0d", k), 5);
            check($sformatf("fair%0d_addr", k), 128'(mem_addr_o),
                  exp_dc[k] ? 128'h0000_0200 : 128'h0000_0100);
            check($sformatf("fair%0d_streak", k), 128'(dut.u_prio.streak_q), 128'(exp_streak[k]));
            mem_ack_i = 1'b1;
            tick();
            mem_ack_i = 1'b0;
            check($sformatf("fair%0d_dc_rvalid", k), 128'(dc_rvalid_o), 128'(exp_dc[k]));
            check($sformatf("fair%0d_ic_rvalid", k), 128'(ic_rvalid_o), 128'(!exp_dc[k]));
        end
        ic_req_i = 1'b0; dc_req_i = 1'b0;
        tick(); tick();
        check("fair_idle", 128'(dut.state), 128'(IDLE));

        // D-side fill with req dropped one cycle after grant
        dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h0000_300F;
        tick();
        check("drop_addr", 128'(mem_addr_o), 128'h0000_3000);
        dc_req_i = 1'b0;
        tick();
        check("drop_state",   128'(dut.state), 128'(DC_BUSY));
        check("drop_mem_req", 128'(mem_req_o), 128'd1);
        mem_ack_i = 1'b1; mem_rdata_i = DATA_5C;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        check("drop_rvalid", 128'(dc_rvalid_o), 128'd1);
        check("drop_rdata",  dc_rdata_o, DATA_5C);
        tick();
        check("drop_rvalid_1cyc", 128'(dc_rvalid_o), 128'd0);

        // Reset in DC_BUSY with a coincident ack
        ic_req_i = 1'b1; dc_req_i = 1'b1;
        tick();
        check("rb_state",  128'(dut.state), 128'(DC_BUSY));
        check("rb_streak", 128'(dut.u_prio.streak_q), 128'd1);
        ic_req_i = 1'b0;
        rsn_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = DATA_E7;
        tick();
        rsn_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = '0; dc_req_i = 1'b0;
        check("rb_idle",      128'(dut.state), 128'(IDLE));
        check("rb_mem_req",   128'(mem_req_o), 128'd0);
        check("rb_dc_rvalid", 128'(dc_rvalid_o), 128'd0);
        check("rb_ic_rvalid", 128'(ic_rvalid_o), 128'd0);
        check("rb_streak0",   128'(dut.u_prio.streak_q), 128'd0);
        tick();
        check("rb_no_late_pulse", 128'(dc_rvalid_o), 128'd0);

        // Stray ack while idle
        mem_ack_i = 1'b1; mem_rdata_i = DATA_E7;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        check("ia_state",     128'(dut.state), 128'(IDLE));
        check("ia_mem_req",   128'(mem_req_o), 128'd0);
        check("ia_ic_rvalid", 128'(ic_rvalid_o), 128'd0);
        check("ia_dc_rvalid", 128'(dc_rvalid_o), 128'd0);
        check("ia_ic_rdata",  ic_rdata_o, 128'd0);
        check("ia_dc_rdata",  dc_rdata_o, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/segre_mem_arbiter.md
SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDR_W, ADDR_SIZE (32), address width.
  LINE_W, CACHE_LINE_SIZE_BITS (128), line width.
  MAX_DC_STREAK, 4, consecutive contended D-side grants before the I-side wins.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_i  in  1  single clock; all state updates on its rising edge.
  rsn_i  in  1  reset, synchronous, active-low.
  ic_req_i  in  1  I-cache line-fill request, held until ic_rvalid_o.
  ic_addr_i  in  ADDR_W  I-side address.
  ic_rvalid_o  out  1  one-cycle I-side completion pulse.
  ic_rdata_o  out  LINE_W  I-side fill data, valid with ic_rvalid_o.
  dc_req_i  in  1  D-cache request, held until dc_rvalid_o.
  dc_we_i  in  1  1 = line write-back, 0 = line fill.
  dc_addr_i  in  ADDR_W  D-side address.
  dc_wdata_i  in  LINE_W  write-back data.
  dc_rvalid_o  out  1  one-cycle D-side completion pulse (read or write).
  dc_rdata_o  out  LINE_W  D-side fill data, valid with dc_rvalid_o.
  mem_req_o  out  1  memory request, held until mem_ack_i.
  mem_we_o  out  1  memory write enable.
  mem_addr_o  out  ADDR_W  line-aligned memory address.
  mem_wdata_o  out  LINE_W  memory write data.
  mem_ack_i  in  1  memory completion, one cycle.
  mem_rdata_i  in  LINE_W  read data, valid with mem_ack_i.

Function
REQ-003 FSM states SHALL be IDLE, IC_BUSY, DC_BUSY and RESP.
REQ-004 IDLE SHALL arbitrate on each cycle: dc only -> DC_BUSY; ic only -> IC_BUSY; neither -> stay in IDLE.
REQ-005 When both requests are asserted in IDLE, dc SHALL win unless the streak counter equals MAX_DC_STREAK, in which case ic wins.
REQ-006 The streak counter SHALL increment, saturating at MAX_DC_STREAK, on a dc grant made while ic_req_i=1; it SHALL clear on any ic grant and on a dc grant made while ic_req_i=0.
REQ-007 On the grant edge, the address, we and wdata SHALL be registered; mem_addr_o SHALL have its low $clog2(LINE_W/8) bits forced to 0; mem_we_o SHALL be 0 for ic grants.
REQ-008 mem_req_o SHALL be 1 throughout IC_BUSY/DC_BUSY and its companion outputs SHALL be stable until mem_ack_i; the grant-to-mem_req_o latency SHALL be 1 cycle.
REQ-009 On mem_ack_i in a busy state, mem_rdata_i SHALL be registered and the FSM SHALL go to RESP.
REQ-010 In RESP, exactly one of ic_rvalid_o/dc_rvalid_o (the owner's) SHALL be 1 for one cycle with rdata valid; RESP SHALL not arbitrate and SHALL return to IDLE.
REQ-011 mem_ack_i SHALL be ignored in IDLE and RESP.
REQ-012 A requester deasserting req mid-transaction SHALL not abort it; the completion pulse is still issued.
REQ-013 Minimum request-to-rvalid latency SHALL be 3 cycles (grant edge, ack in first busy cycle, RESP).
REQ-014 rdata outputs SHALL hold their last captured value outside RESP.

Reset
REQ-015 When rsn_i=0 at a clock edge: FSM SHALL go to IDLE; streak counter, mem_req_o, mem_we_o, ic_rvalid_o and dc_rvalid_o SHALL go to 0; the address/data registers SHALL go to 0.
REQ-016 A reset in a busy state SHALL drop mem_req_o at that edge with no completion pulse; an in-flight mem_ack_i SHALL be ignored.

Structure
REQ-017 arb_state_e (IDLE, IC_BUSY, DC_BUSY, RESP) and arb_owner_e (OWNER_IC, OWNER_DC) SHALL be added to segre_pkg; widths SHALL derive from ADDR_SIZE and CACHE_LINE_SIZE_BITS.
REQ-018 The streak counter and priority decision SHALL be one sub-module, segre_arb_prio; the FSM and datapath registers SHALL stay in the top.

Verification
REQ-019 ic only, addr 0x0000_1234, ack 2 cycles after mem_req_o with rdata 0xA5..A5 -> mem_addr_o=0x0000_1230, mem_we_o=0, ic_rvalid_o one cycle, ic_rdata_o=0xA5..A5.
REQ-020 dc write-back, addr 0x0000_2000, wdata 0x1111..11 -> mem_we_o=1, mem_wdata_o=0x1111..11, dc_rvalid_o one cycle, no ic_rvalid_o.
REQ-021 ic and dc held continuously, ack after 1 cycle each -> grant order dc,dc,dc,dc,ic,dc..., streak returns to 0 after the ic grant.
REQ-022 dc request dropped one cycle after grant -> transaction completes and dc_rvalid_o still pulses.
REQ-023 rsn_i=0 in DC_BUSY with mem_ack_i=1 the same cycle -> next cycle IDLE, mem_req_o=0, no rvalid pulse, streak=0.
REQ-024 mem_ack_i pulsed while in IDLE -> no state change and no rvalid.
